// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, state encoding and word types for the instruction loader.
package imem_loader_pkg;
    localparam int DATA_W = 19;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_e;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   count_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: program word stream plus the CPU fetch port.
interface imem_loader_if;
    import imem_loader_pkg::*;
    logic  in_valid;
    word_t in_data;
    logic  in_last;
    logic  in_ready;
    addr_t fetch_addr;
    word_t fetch_instr;
    modport master (output in_valid, in_data, in_last, fetch_addr, input in_ready, fetch_instr);
    modport slave  (input in_valid, in_data, in_last, fetch_addr, output in_ready, fetch_instr);
endinterface

// File: rtl/imem_loader_ram.sv
// imem_loader_ram: single-write, asynchronous-read instruction array (read sees old data on collision).
module imem_loader_ram
    import imem_loader_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t waddr,
    input  word_t wdata,
    input  addr_t raddr,
    output word_t rdata
);
    word_t mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory, holding the CPU in reset until loaded.
// Define IMEM_LOADER_CHECKSUM_EN to treat the last word as an XOR checksum instead of an instruction.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         load_done,
    output logic         load_error,
    output count_t       load_count
);
    state_e state_q;
    count_t load_count_q;
    logic   cpu_reset_q, load_done_q, load_error_q;
    logic   xfer, we;
    assign bus.in_ready = state_q == LOAD;
    assign xfer = bus.in_valid && bus.in_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
    word_t csum_q;
    logic  full, csum_ok;
    // Only data words are stored; a full count blocks the wrap back to address 0.
    assign full = load_count_q[ADDR_W];
    assign csum_ok = bus.in_data == csum_q;
    assign we = xfer && !bus.in_last && !full;
`else
    assign we = xfer;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            load_count_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, RUN, ERROR: if (start) begin
                    state_q      <= LOAD;
                    load_count_q <= '0;
                    cpu_reset_q  <= 1'b1;
                    load_done_q  <= 1'b0;
                    load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_q       <= '0;
`endif
                end
                LOAD: if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (bus.in_last) begin
                        state_q      <= csum_ok ? RUN : ERROR;
                        cpu_reset_q  <= !csum_ok;
                        load_done_q  <= csum_ok;
                        load_error_q <= !csum_ok;
                    end else if (full) begin
                        state_q      <= ERROR;
                        load_error_q <= 1'b1;
                    end else begin
                        load_count_q <= load_count_q + 1'b1;
                        csum_q       <= csum_q ^ bus.in_data;
                    end
`else
                    load_count_q <= load_count_q + 1'b1;
                    if (bus.in_last) begin
                        state_q     <= RUN;
                        cpu_reset_q <= 1'b0;
                        load_done_q <= 1'b1;
                    end else if (load_count_q == count_t'(DEPTH - 1)) begin
                        state_q      <= ERROR;
                        load_error_q <= 1'b1;
                    end
`endif
                end
            endcase
        end
    end
    imem_loader_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (load_count_q[ADDR_W-1:0]),
        .wdata (bus.in_data),
        .raddr (bus.fetch_addr),
        .rdata (bus.fetch_instr)
    );
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign load_count = load_count_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed plan items plus randomized loads against a program-level reference model.
module tb_imem_loader;
    import imem_loader_pkg::*;
    logic   clk = 1'b0;
    logic   reset;
    logic   start;
    logic   cpu_reset, load_done, load_error;
    count_t load_count;
    int     checks = 0;
    int     errors = 0;
    bit     chk_en = 1'b0;
    bit     rnd_fetch = 1'b0;
    imem_loader_if bus ();
    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .load_count (load_count)
    );
    always #5 clk = ~clk;
    // Reference: phase of the loader (0 idle, 1 loading, 2 running, 3 failed), words kept, memory image.
    int    ph = 0;
    int    mcnt = 0;
    word_t mx = '0;
    word_t mmem [DEPTH];
    bit    mval [DEPTH];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph = 0;
            mcnt = 0;
        end else if (ph == 1) begin
            if (bus.in_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (bus.in_last) ph = (bus.in_data == mx) ? 2 : 3;
                else if (mcnt == DEPTH) ph = 3;
                else begin
                    mmem[mcnt] = bus.in_data;
                    mval[mcnt] = 1'b1;
                    mcnt++;
                    mx ^= bus.in_data;
                end
`else
                mmem[mcnt % DEPTH] = bus.in_data;
                mval[mcnt % DEPTH] = 1'b1;
                mcnt++;
                if (bus.in_last) ph = 2;
                else if (mcnt == DEPTH) ph = 3;
`endif
            end
        end else if (start) begin
            ph = 1;
            mcnt = 0;
            mx = '0;
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_reset", 32'(cpu_reset), 32'(ph != 2));
            chk("load_done", 32'(load_done), 32'(ph == 2));
            chk("load_error", 32'(load_error), 32'(ph == 3));
            chk("in_ready", 32'(bus.in_ready), 32'(ph == 1));
            chk("load_count", 32'(load_count), 32'(mcnt));
            if (mval[bus.fetch_addr]) chk("fetch_instr", 32'(bus.fetch_instr), 32'(mmem[bus.fetch_addr]));
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_fetch) bus.fetch_addr = ADDR_W'($urandom());
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic send(input word_t d, input bit l, input int gap);
        bit ok = 1'b0;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_last = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("send_accept", 32'(ok), 32'd1);
    endtask
    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.fetch_addr = '0;
        #12 reset = 1'b0;
        chk_en = 1'b1;
        tick();
        // Asynchronous reset out of a partial load, checked before any edge.
        pulse_start();
        send(19'h1ABCD, 1'b0, 0);
        #2 reset = 1'b1;
        #1;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        reset = 1'b0;
        tick();
        pulse_start();
        send(19'h00001, 1'b0, 1);
        send(19'h12345, 1'b0, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(19'h12344, 1'b1, 1);
        chk("t2_count", 32'(load_count), 32'd2);
`else
        send(19'h7FFFF, 1'b1, 1);
        chk("t2_count", 32'(load_count), 32'd3);
`endif
        chk("t2_done", 32'(load_done), 32'd1);
        chk("t2_cpu_reset", 32'(cpu_reset), 32'd0);
        bus.fetch_addr = 5'd1;
        #1 chk("t2_fetch1", 32'(bus.fetch_instr), 32'h12345);
`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        send(19'h00003, 1'b0, 0);
        send(19'h00005, 1'b0, 0);
        send(19'h00006, 1'b1, 0);
        chk("t6_done", 32'(load_done), 32'd1);
        chk("t6_count", 32'(load_count), 32'd2);
        pulse_start();
        send(19'h00003, 1'b0, 0);
        send(19'h00005, 1'b0, 0);
        send(19'h00007, 1'b1, 0);
        chk("t6_error", 32'(load_error), 32'd1);
        chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
        pulse_start();
        send(19'h00000, 1'b1, 0);
        chk("t6_empty_done", 32'(load_done), 32'd1);
        chk("t6_empty_count", 32'(load_count), 32'd0);
`endif
        pulse_start();
        chk("t3_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) send(word_t'(19'h100 + i), 1'b0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t3_still_loading", 32'(bus.in_ready), 32'd1);
        send(19'h00200, 1'b0, 0);
`endif
        chk("t3_error", 32'(load_error), 32'd1);
        chk("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t3_count", 32'(load_count), 32'd32);
        chk("t3_ready_low", 32'(bus.in_ready), 32'd0);
        bus.fetch_addr = 5'd31;
        #1 chk("t3_fetch31", 32'(bus.fetch_instr), 32'h11F);
        bus.fetch_addr = 5'd0;
        #1 chk("t3_fetch0", 32'(bus.fetch_instr), 32'h100);
        pulse_start();
        chk("t3_err_clear", 32'(load_error), 32'd0);
        chk("t3_reload", 32'(bus.in_ready), 32'd1);
        send(19'h00011, 1'b0, 0);
        send(19'h00022, 1'b0, 0);
        bus.fetch_addr = 5'd2;
        bus.in_valid = 1'b1;
        bus.in_data = 19'h00055;
`ifdef IMEM_LOADER_CHECKSUM_EN
        bus.in_last = 1'b0;
`else
        bus.in_last = 1'b1;
`endif
        @(negedge clk);
        chk("t5_old", 32'(bus.fetch_instr), 32'h102);
        tick();
        bus.in_valid = 1'b0;
        chk("t5_new", 32'(bus.fetch_instr), 32'h55);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(19'h00066, 1'b1, 0);
`endif
        chk("t5_run", 32'(load_done), 32'd1);
        pulse_start();
        chk("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t4_done_low", 32'(load_done), 32'd0);
        chk("t4_count0", 32'(load_count), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(19'h0000A, 1'b0, 0);
`endif
        send(19'h0000A, 1'b1, 0);
        chk("t4_count", 32'(load_count), 32'd1);
        chk("t4_run", 32'(load_done), 32'd1);
        chk("t4_cpu_run", 32'(cpu_reset), 32'd0);
        bus.fetch_addr = 5'd0;
        #1 chk("t4_fetch0", 32'(bus.fetch_instr), 32'hA);
        rnd_fetch = 1'b1;
        for (int k = 0; k < 60; k++) begin
            int    n;
            bit    ovf;
            word_t x = '0;
            if ($urandom_range(0, 9) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
                tick();
            end
            pulse_start();
            ovf = $urandom_range(0, 7) == 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            n = ovf ? DEPTH + 1 : int'($urandom_range(0, DEPTH));
`else
            n = ovf ? DEPTH : int'($urandom_range(1, DEPTH));
`endif
            for (int i = 0; i < n; i++) begin
                word_t d = word_t'($urandom());
                x ^= d;
                start = $urandom_range(0, 15) == 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                send(d, 1'b0, int'($urandom_range(0, 2)));
`else
                send(d, !ovf && i == n - 1, int'($urandom_range(0, 2)));
`endif
                start = 1'b0;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (!ovf) send(($urandom_range(0, 3) == 0) ? x ^ word_t'($urandom_range(1, 255)) : x, 1'b1, 0);
`endif
            repeat ($urandom_range(0, 3)) tick();
        end
        rnd_fetch = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream stage of the single-cycle CPU; replaces the fixed instruction ROM.
- Owns a 32 x 19-bit instruction memory. Loads it from a valid/ready word stream.
- Holds the CPU in reset while loading, then releases it. The CPU fetches through a combinational read port.

Parameters:
- DATA_W, 19, instruction width.
- ADDR_W, 5, instruction address width; matches the CPU PC.
- DEPTH, 32, memory entries; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a (re)load.
- in_valid  input  1  stream word valid.
- in_data  input  DATA_W  stream word.
- in_last  input  1  marks the final word of the program.
- in_ready  output  1  loader accepts a word this cycle.
- fetch_addr  input  ADDR_W  CPU instruction address.
- fetch_instr  output  DATA_W  instruction at fetch_addr.
- cpu_reset  output  1  drives the CPU reset; high while not RUN.
- load_done  output  1  program loaded; CPU running.
- load_error  output  1  load aborted.
- load_count  output  ADDR_W+1  words written by the last/current load.

Behaviour:
- Clock and reset: single clock domain, clk. reset is asynchronous and active-high.
- On reset:
  - State is IDLE.
  - cpu_reset=1, in_ready=0, load_done=0, load_error=0, load_count=0.
  - Memory contents are not reset; they are undefined until first load.
- States: IDLE, LOAD, RUN, ERROR. All outputs are registered except fetch_instr and in_ready. in_ready is decoded from the state.
- IDLE:
  - in_ready=0, cpu_reset=1.
  - start=1 -> LOAD; load_count cleared to 0.
- LOAD:
  - in_ready=1, cpu_reset=1, load_done=0.
  - A transfer occurs when in_valid&in_ready. It writes mem[load_count]=in_data at the clock edge, then load_count++.
  - A transfer with in_last=1 -> RUN.
  - A transfer at address DEPTH-1 with in_last=0 -> ERROR (overflow). That word is still written and load_count becomes 32.
  - in_valid=0 stalls indefinitely; no timeout.
  - start during LOAD is ignored.
- RUN:
  - cpu_reset falls and load_done rises on the edge entering RUN. The CPU's first fetch is address 0 on the next cycle.
  - in_ready=0; memory is write-protected.
  - start=1 -> LOAD on that edge. cpu_reset=1, load_done=0, load_count=0 take effect together.
- ERROR:
  - cpu_reset=1, load_error=1, in_ready=0.
  - start=1 -> LOAD and clears load_error. reset also exits ERROR.
- Fetch:
  - fetch_instr=mem[fetch_addr] combinationally.
  - A write and a read of the same address in the same cycle return the old data; the new data appears after the edge.
- Reset asserted mid-load: memory keeps its partial contents; the FSM returns to IDLE immediately.
- Width rules:
  - load_count is ADDR_W+1 bits, so a value of 32 is representable.
  - The write address is load_count[ADDR_W-1:0].

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - The word carrying in_last is a checksum. It is not written and does not increment load_count.
  - The block keeps a running XOR of all data words, cleared on entry to LOAD.
  - checksum == running XOR -> RUN; mismatch -> ERROR.
  - An empty program (first word is last, value 0) -> RUN with load_count=0.
  - Overflow applies only to data words: a 33rd data word -> ERROR.
- Undefined: the last word is an instruction, as described above. No XOR logic is synthesized.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W=19, ADDR_W=5, DEPTH=32.
  - Loader state enum {IDLE, LOAD, RUN, ERROR}.
- One sub-module: imem_ram, a 1-write/1-async-read array with ports clk, we, waddr, wdata, raddr, rdata. The FSM and checksum stay in imem_loader.

Test Plan:
1. reset pulse -> cpu_reset=1, in_ready=0, load_done=0, load_error=0, load_count=0 asynchronously, before any clk edge.
2. start; stream 0x00001, 0x12345, 0x7FFFF with in_last on the 3rd, in_valid toggling 1/0 -> load_count=3, load_done=1, cpu_reset=0 on the edge after the 3rd transfer; fetch_addr=1 returns 0x12345.
3. start; 32 words, none marked last -> load_error=1, cpu_reset=1, load_count=32, in_ready=0; a following start clears load_error and returns to LOAD.
4. In RUN, pulse start and reload the single word 0x0000A -> cpu_reset high one edge after start, load_count=1, mem[0]=0x0000A, then RUN again.
5. Same-cycle write mem[2]=0x00055 with fetch_addr=2 -> fetch_instr shows the old value that cycle and 0x00055 the next.
6. (IMEM_LOADER_CHECKSUM_EN) words 0x00003, 0x00005, checksum 0x00006 -> RUN, load_count=2. Checksum 0x00007 instead -> ERROR, cpu_reset stays 1.
